switch_key_in: RTL and testbench
================================

Name: switch_key_in

Overview:
- Memory-mapped input peripheral: the read-side counterpart of the LED output register on the CPU bridge.
- Samples 32 DIP switches and 8 push keys, synchronizes and debounces them, latches key press edges, and exposes everything as word registers.
- The CPU reads the registers through the bridge with zero-cycle (combinational) read data.
- Sits beside the LED block behind the system bridge.

Parameters:
- DEBOUNCE_CYCLES, 20000, consecutive stable synchronized cycles required before a group's debounced value updates (>=2).
- KEY_ACTIVE_LOW, 1, 1: key_in is inverted before synchronization, so pressed reads as 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- addr  input  2  word select: 0=SW, 1=KEY, 2=EDGE, 3=MASK
- we  input  1  bus write strobe
- byteen  input  4  byte enables for writes
- wdata  input  32  write data
- rdata  output  32  read data, combinational on addr
- sw_in  input  32  raw asynchronous switch pins
- key_in  input  8  raw asynchronous key pins
- irq  output  1  level interrupt request

Behaviour:
- Clock and reset:
  - One clock, clk. reset is synchronous and active-high, sampled only at posedge clk.
  - Reset clears every register: sync stages, previous-sync copies, counters, stable values, EDGE and MASK.
  - Reset mid-debounce discards the pending count; no edge is produced by the reset itself.
- Synchronizer: each input bit passes through a 2-flop synchronizer (s1 then sync), after KEY_ACTIVE_LOW inversion for keys.
- Debounce, per group (the SW group and the KEY group each have one counter cnt, width clog2(DEBOUNCE_CYCLES), plus sync_prev):
  - If sync != sync_prev: cnt <= 0.
  - Else if sync == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - Else: cnt <= cnt+1.
  - sync_prev <= sync every cycle.
- Debounce latency: a raw change that holds steady appears in stable exactly DEBOUNCE_CYCLES+3 posedges after the first edge that samples it. Any glitch restarts the count.
- Edge latch:
  - EDGE[i] sets when the KEY group's stable[i] goes 0->1, i.e. on the cycle stable updates.
  - Bits [31:8] read 0.
- Register reads:
  - SW = sw stable.
  - KEY = {24'b0, key stable}.
  - EDGE = {24'b0, edge}.
  - MASK = {24'b0, mask}.
- Writes (only when we=1):
  - SW and KEY are read-only; writes are ignored.
  - EDGE is write-1-to-clear, using byte 0 only (byteen[0]).
  - MASK is written with wdata[7:0] when byteen[0] is set.
  - Other byte lanes are ignored.
- Simultaneous set and W1C clear on the same bit in the same cycle: the set wins and the bit stays 1.
- irq = |(EDGE & MASK), registered-free combinational from flops; reset value 0.
- rdata reset value: SW reads 0 immediately after reset.

Optional Feature:
- Macro: SWITCH_KEY_IRQ_EN.
- Defined: MASK register exists and irq behaves as above.
- Undefined:
  - MASK flops are not built; MASK reads 0 and writes to it are ignored.
  - irq is tied to 0.
  - EDGE latching and W1C are still present.

Test Plan (DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1):
- Reset check: assert reset 2 cycles with sw_in=32'hFFFF_FFFF, release -> SW=0 for the next 6 cycles, then SW=32'hFFFF_FFFF after the 7th posedge; EDGE=0 and irq=0 throughout reset.
- Glitch rejection: sw_in 0->32'h0000_00A5 for 3 cycles, back to 0, then to 32'h0000_00A5 and hold -> SW never shows A5 during the glitch; SW=32'h0000_00A5 exactly 7 posedges after the hold begins.
- Key press: key_in[3] driven 1->0 and held -> KEY=32'h0000_0008 and EDGE=32'h0000_0008 on the same cycle; release (key_in[3]=1, debounced) -> KEY=0, EDGE stays 8.
- W1C clear: write EDGE wdata=8, byteen=4'b0001 -> EDGE=0 next cycle. Same write with byteen=4'b0010 -> EDGE unchanged. Write coinciding with a new rising edge on bit 3 -> EDGE bit 3 stays 1.
- IRQ (macro on): MASK=8'h08 with EDGE[3]=1 -> irq=1; MASK=0 -> irq=0. Macro off: irq=0 and MASK reads 0 after writing 8'hFF.
- Read-only: write SW and KEY with 32'hDEAD_BEEF, byteen=4'hF -> read values unchanged.

Source files
------------

// File: rtl/switch_key_in.sv
// rtl/switch_key_in.sv - debounced switch/key input registers with latched key press edges
// Optional SWITCH_KEY_IRQ_EN builds the MASK register and drives irq from EDGE & MASK.

module switch_key_in_debounce #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] stable_nxt
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] sync_prev;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;

  // The whole group shares one counter: any bit moving restarts the count.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    if (sync != sync_prev) begin
      cnt_nxt = '0;
    end else if (sync == stable) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      stable_nxt = sync;
      cnt_nxt    = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      sync      <= '0;
      sync_prev <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else begin
      s1        <= raw;
      sync      <= s1;
      sync_prev <= sync;
      cnt       <= cnt_nxt;
      stable    <= stable_nxt;
    end
  end

endmodule

module switch_key_in #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] sw_in,
  input  logic [7:0]  key_in,
  output logic        irq
);

  localparam logic [1:0] ADDR_SW   = 2'd0;
  localparam logic [1:0] ADDR_KEY  = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_MASK = 2'd3;

  logic [7:0]  key_raw;
  logic [31:0] sw_stable;
  logic [31:0] sw_stable_nxt;
  logic [7:0]  key_stable;
  logic [7:0]  key_stable_nxt;
  logic [7:0]  edge_q;
  logic [7:0]  edge_nxt;
  logic [7:0]  edge_clr;
  logic [7:0]  mask_val;
  logic        edge_wr;
  logic        unused_bits;

  assign key_raw = (KEY_ACTIVE_LOW != 0) ? ~key_in : key_in;

  switch_key_in_debounce #(
    .WIDTH  (32),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk        (clk),
    .reset      (reset),
    .raw        (sw_in),
    .stable     (sw_stable),
    .stable_nxt (sw_stable_nxt)
  );

  switch_key_in_debounce #(
    .WIDTH  (8),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_key_db (
    .clk        (clk),
    .reset      (reset),
    .raw        (key_raw),
    .stable     (key_stable),
    .stable_nxt (key_stable_nxt)
  );

  assign edge_wr  = we && (addr == ADDR_EDGE) && byteen[0];
  assign edge_clr = edge_wr ? wdata[7:0] : 8'h00;

  // The rising edge is taken from the next stable value so EDGE sets on the
  // same posedge KEY changes; the set term is OR-ed last so it beats W1C.
  always_comb begin
    edge_nxt = (edge_q & ~edge_clr) | (key_stable_nxt & ~key_stable);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_q <= '0;
    end else begin
      edge_q <= edge_nxt;
    end
  end

`ifdef SWITCH_KEY_IRQ_EN
  logic [7:0] mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
    end else if (we && (addr == ADDR_MASK) && byteen[0]) begin
      mask_q <= wdata[7:0];
    end
  end

  assign mask_val = mask_q;
  assign irq      = |(edge_q & mask_q);
`else
  assign mask_val = 8'h00;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rdata = 32'h0;
    case (addr)
      ADDR_SW:   rdata = sw_stable;
      ADDR_KEY:  rdata = {24'h0, key_stable};
      ADDR_EDGE: rdata = {24'h0, edge_q};
      ADDR_MASK: rdata = {24'h0, mask_val};
      default:   rdata = 32'h0;
    endcase
  end

  assign unused_bits = ^{wdata[31:8], byteen[3:1], sw_stable_nxt};

endmodule

// File: tb/tb_switch_key_in.sv
// tb/tb_switch_key_in.sv - self-checking bench for switch_key_in with DEBOUNCE_CYCLES=4
// Builds with or without SWITCH_KEY_IRQ_EN.

module tb_switch_key_in;

  localparam int DEB = 4;
`ifdef SWITCH_KEY_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] sw_in;
  logic [7:0]  key_in;
  logic        irq;

  switch_key_in #(
    .DEBOUNCE_CYCLES (DEB),
    .KEY_ACTIVE_LOW  (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .sw_in  (sw_in),
    .key_in (key_in),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
    logic        exp_irq;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vec[10];
  int   n_tests;
  int   n_fail;

  task automatic push_exp(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    sb_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s actual=%h expected=%h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    push_exp(name, exp);
    addr = a;
    #1;
    pop_cmp(rdata);
  endtask

  task automatic irq_chk(input logic exp, input string name);
    push_exp(name, {31'h0, exp});
    pop_cmp({31'h0, irq});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    addr    = 2'd0;
    we      = 1'b0;
    byteen  = 4'h0;
    wdata   = 32'h0;
    sw_in   = 32'hFFFF_FFFF;
    key_in  = 8'hFF;

    vec[0] = '{"edge_w1c_lane1_ignored", 1'b1, 2'd2, 4'b0010, 32'h0000_0008, 2'd2, 32'h0000_0008, 1'b0};
    vec[1] = '{"sw_read_only",           1'b1, 2'd0, 4'hF,    32'hDEAD_BEEF, 2'd0, 32'h0000_00A5, 1'b0};
    vec[2] = '{"key_read_only",          1'b1, 2'd1, 4'hF,    32'hDEAD_BEEF, 2'd1, 32'h0000_0000, 1'b0};
    vec[3] = '{"edge_no_we",             1'b0, 2'd2, 4'b0001, 32'h0000_0008, 2'd2, 32'h0000_0008, 1'b0};
    vec[4] = '{"mask_08",                1'b1, 2'd3, 4'b0001, 32'h0000_0008, 2'd3, IRQ_ON ? 32'h8 : 32'h0, IRQ_ON};
    vec[5] = '{"mask_00",                1'b1, 2'd3, 4'b0001, 32'h0000_0000, 2'd3, 32'h0000_0000, 1'b0};
    vec[6] = '{"mask_ff",                1'b1, 2'd3, 4'b0001, 32'h0000_00FF, 2'd3, IRQ_ON ? 32'hFF : 32'h0, IRQ_ON};
    vec[7] = '{"mask_lane1_ignored",     1'b1, 2'd3, 4'b0010, 32'h0000_0000, 2'd3, IRQ_ON ? 32'hFF : 32'h0, IRQ_ON};
    vec[8] = '{"edge_w1c_clear",         1'b1, 2'd2, 4'b0001, 32'h0000_0008, 2'd2, 32'h0000_0000, 1'b0};
    vec[9] = '{"mask_clear",             1'b1, 2'd3, 4'b0001, 32'h0000_0000, 2'd3, 32'h0000_0000, 1'b0};

    // Reset with all switches on: SW must stay 0 until DEB+3 posedges after release.
    for (int i = 0; i < 2; i++) begin
      step();
      read_chk(2'd0, 32'h0, "reset_sw");
      read_chk(2'd2, 32'h0, "reset_edge");
      irq_chk(1'b0, "reset_irq");
    end
    reset = 1'b0;
    for (int i = 1; i < DEB + 3; i++) begin
      step();
      read_chk(2'd0, 32'h0, "post_reset_sw_zero");
    end
    step();
    read_chk(2'd0, 32'hFFFF_FFFF, "post_reset_sw_ones");

    // Return switches to 0, then a 3-cycle glitch that must be rejected.
    sw_in = 32'h0;
    for (int i = 0; i < 10; i++) step();
    read_chk(2'd0, 32'h0, "sw_settle_zero");
    sw_in = 32'h0000_00A5;
    for (int i = 0; i < 3; i++) begin
      step();
      read_chk(2'd0, 32'h0, "glitch_high");
    end
    sw_in = 32'h0;
    for (int i = 0; i < 8; i++) begin
      step();
      read_chk(2'd0, 32'h0, "glitch_low");
    end
    sw_in = 32'h0000_00A5;
    for (int i = 1; i < DEB + 3; i++) begin
      step();
      read_chk(2'd0, 32'h0, "hold_before_update");
    end
    step();
    read_chk(2'd0, 32'h0000_00A5, "hold_updated");

    // Key 3 press (active low) and release.
    key_in = 8'hF7;
    for (int i = 1; i < DEB + 3; i++) begin
      step();
      read_chk(2'd1, 32'h0, "press_key_pending");
      read_chk(2'd2, 32'h0, "press_edge_pending");
    end
    step();
    read_chk(2'd1, 32'h8, "press_key");
    read_chk(2'd2, 32'h8, "press_edge");
    key_in = 8'hFF;
    for (int i = 0; i < DEB + 3; i++) step();
    read_chk(2'd1, 32'h0, "release_key");
    read_chk(2'd2, 32'h8, "release_edge_held");

    // Register access table: one write cycle, then read back and check irq.
    foreach (vec[i]) begin
      we     = vec[i].we;
      addr   = vec[i].waddr;
      byteen = vec[i].be;
      wdata  = vec[i].wdata;
      step();
      we     = 1'b0;
      byteen = 4'h0;
      wdata  = 32'h0;
      read_chk(vec[i].raddr, vec[i].exp, vec[i].name);
      irq_chk(vec[i].exp_irq, {vec[i].name, "_irq"});
    end

    // W1C on the same posedge as a new rising edge on bit 3: set wins.
    key_in = 8'hF7;
    for (int i = 1; i < DEB + 3; i++) step();
    read_chk(2'd2, 32'h0, "coincide_edge_before");
    we     = 1'b1;
    addr   = 2'd2;
    byteen = 4'b0001;
    wdata  = 32'h0000_0008;
    step();
    we     = 1'b0;
    byteen = 4'h0;
    read_chk(2'd2, 32'h8, "coincide_set_wins");
    read_chk(2'd1, 32'h8, "coincide_key");
    key_in = 8'hFF;
    for (int i = 0; i < DEB + 3; i++) step();
    we     = 1'b1;
    addr   = 2'd2;
    byteen = 4'b0001;
    wdata  = 32'h0000_00FF;
    step();
    we     = 1'b0;
    byteen = 4'h0;
    read_chk(2'd2, 32'h0, "edge_cleared_again");

    // Reset in the middle of a key debounce discards it and makes no edge.
    key_in = 8'hF7;
    for (int i = 0; i < 4; i++) step();
    reset  = 1'b1;
    key_in = 8'hFF;
    step();
    reset = 1'b0;
    for (int i = 0; i < DEB + 4; i++) begin
      step();
      read_chk(2'd1, 32'h0, "mid_reset_key");
      read_chk(2'd2, 32'h0, "mid_reset_edge");
    end

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
